// File: rtl/axis_to_uart_tx.sv
// AXI-Stream to UART transmitter.
// Accepts one word per frame on an AXI-Stream sink and serialises it as
// start bit, BIT_PER_WORD data bits (LSB first), optional parity and
// one or two stop bits. Every line bit lasts floor(CLK_FREQ*1e6/BIT_RATE) clocks.
//
// Ports:
//   aclk    - clock, all state changes on its rising edge
//   aresetn - asynchronous active-low reset
//   tdata   - word to transmit
//   tvalid  - tdata valid
//   tready  - high only while idle, i.e. when a new word can be accepted
//   tuser   - ignored
//   TX      - registered serial line, idles high
module axis_to_uart_tx #(
  parameter int unsigned CLK_FREQ      = 100,     // MHz
  parameter int unsigned BIT_RATE      = 115200,  // bit/s
  parameter int unsigned BIT_PER_WORD  = 8,       // 5..9
  parameter int unsigned PARITY_BIT    = 0,       // 0 none, 1 odd, 2 even
  parameter int unsigned STOP_BITS_NUM = 1        // 1 or 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [BIT_PER_WORD-1:0] tdata,
  input  logic                    tvalid,
  output logic                    tready,
  input  logic                    tuser,
  output logic                    TX
);

  localparam int unsigned BitPeriod = CLK_FREQ * 1000000 / BIT_RATE;
  localparam int unsigned CntW      = $clog2(BitPeriod + 1);
  localparam int unsigned BitW      = $clog2(BIT_PER_WORD + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(BitPeriod - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(BIT_PER_WORD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BIT_PER_WORD-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    bit_end;

  logic unused_tuser;
  assign unused_tuser = tuser;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tready    = (state_q == StIdle);
    bit_end   = (clk_cnt_q == CntLast);

    if (state_q == StIdle) begin
      if (tvalid) begin
        shift_d   = tdata;
        // Parity is fixed from the word at the handshake, not from the shifted copy.
        parity_d  = (PARITY_BIT == 1) ? ~^tdata : ^tdata;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = StStart;
      end
    end else if (!bit_end) begin
      clk_cnt_d = clk_cnt_q + CntW'(1);
    end else begin
      clk_cnt_d = '0;
      case (state_q)
        StStart: state_d = StData;
        StData: begin
          if (bit_cnt_q == BitLast) begin
            state_d = (PARITY_BIT != 0) ? StParity : StStop1;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            shift_d   = shift_q >> 1;
          end
        end
        StParity: state_d = StStop1;
        StStop1:  state_d = (STOP_BITS_NUM == 2) ? StStop2 : StIdle;
        default:  state_d = StIdle;
      endcase
    end

    // Line level is registered: derive it from the state being entered.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Directed bench for axis_to_uart_tx at P = 100 clocks per bit.
// Four instances: 8N1, 8E1, 8O1 and 8N2, sharing clock, reset and tdata.
module tb_axis_to_uart_tx;

  localparam int unsigned P = 100;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [7:0] tdata;
  logic       tvalid [4];
  logic       tready [4];
  logic       tx     [4];

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc          = 0;
  bit          scramble     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_to_uart_tx #(.CLK_FREQ(100), .BIT_RATE(1000000), .BIT_PER_WORD(8),
                    .PARITY_BIT(0), .STOP_BITS_NUM(1)) u_8n1 (
    .aclk(clk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid[0]),
    .tready(tready[0]), .tuser(1'b0), .TX(tx[0]));
  axis_to_uart_tx #(.CLK_FREQ(100), .BIT_RATE(1000000), .BIT_PER_WORD(8),
                    .PARITY_BIT(2), .STOP_BITS_NUM(1)) u_8e1 (
    .aclk(clk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid[1]),
    .tready(tready[1]), .tuser(1'b0), .TX(tx[1]));
  axis_to_uart_tx #(.CLK_FREQ(100), .BIT_RATE(1000000), .BIT_PER_WORD(8),
                    .PARITY_BIT(1), .STOP_BITS_NUM(1)) u_8o1 (
    .aclk(clk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid[2]),
    .tready(tready[2]), .tuser(1'b1), .TX(tx[2]));
  axis_to_uart_tx #(.CLK_FREQ(100), .BIT_RATE(1000000), .BIT_PER_WORD(8),
                    .PARITY_BIT(0), .STOP_BITS_NUM(2)) u_8n2 (
    .aclk(clk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid[3]),
    .tready(tready[3]), .tuser(1'b0), .TX(tx[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampling just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (scramble) tdata = 8'($urandom);
  endtask

  // Send word w on instance d and check every bit at its first and last clock.
  // exp[i] is the line level of bit i in time order.
  task automatic frame_check(input int d, input logic [7:0] w, input int nbits,
                             input logic [11:0] exp, input bit scr, input string tag);
    int unsigned c0;
    int          n;
    tdata     = w;
    tvalid[d] = 1'b1;
    step();
    if (!scr) tvalid[d] = 1'b0;
    scramble = scr;
    c0       = cyc;
    check({tag, "_tready_busy"}, tready[d], 1'b0);
    for (int b = 0; b < nbits; b++) begin
      check($sformatf("%s_b%0d_first", tag, b), tx[d], exp[b]);
      repeat (P - 1) step();
      check($sformatf("%s_b%0d_last", tag, b), tx[d], exp[b]);
      if (b < nbits - 1) step();
    end
    scramble  = 1'b0;
    tvalid[d] = 1'b0;
    n = 0;
    while (tready[d] !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_busy_clocks"}, cyc - c0, nbits * P);
    check({tag, "_idle_tx"}, tx[d], 1'b1);
  endtask

  // Bench UART receiver: find the start bit, sample mid-bit.
  task automatic uart_rx(input int d, output logic [7:0] b, output int unsigned t0);
    int n = 0;
    b = '0;
    while (tx[d] !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    check("rx_start_seen", (n < 3000), 1'b1);
    t0 = cyc;
    repeat (P / 2) step();
    check("rx_start_mid", tx[d], 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (P) step();
      b[i] = tx[d];
    end
    repeat (P) step();
    check("rx_stop_mid", tx[d], 1'b1);
  endtask

  initial begin
    logic [7:0]  rx_b;
    int unsigned t0, t1, t2;
    int          zeros;

    aresetn = 1'b0;
    tdata   = 8'h00;
    for (int i = 0; i < 4; i++) tvalid[i] = 1'b0;

    // Reset state
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), tx[i], 1'b1);
      check($sformatf("rst_tready%0d", i), tready[i], 1'b1);
    end

    // 8N1 0xA5, handshake on the first edge after reset release
    @(negedge clk);
    aresetn = 1'b1;
    frame_check(0, 8'hA5, 10, 12'b00_1_10100101_0, 1'b0, "n1_a5");

    // 8E1 0xA5: parity 0; 8O1 0xA5: parity 1
    frame_check(1, 8'hA5, 11, 12'b0_1_0_10100101_0, 1'b0, "e1_a5");
    frame_check(2, 8'hA5, 11, 12'b0_1_1_10100101_0, 1'b0, "o1_a5");

    // 8N2 0x00
    frame_check(3, 8'h00, 11, 12'b0_1_1_00000000_0, 1'b0, "n2_00");

    // Back-to-back with tvalid held
    tdata     = 8'h01;
    tvalid[0] = 1'b1;
    uart_rx(0, rx_b, t0);
    check("b2b_word0", rx_b, 8'h01);
    tdata = 8'h80;
    uart_rx(0, rx_b, t1);
    check("b2b_word1", rx_b, 8'h80);
    check("b2b_gap01", t1 - t0, 10 * P + 1);
    tdata = 8'hFF;
    uart_rx(0, rx_b, t2);
    tvalid[0] = 1'b0;
    check("b2b_word2", rx_b, 8'hFF);
    check("b2b_gap12", t2 - t1, 10 * P + 1);

    // Stays idle with tvalid low
    zeros = 0;
    repeat (300) begin
      step();
      if (tx[0] !== 1'b1) zeros++;
    end
    check("idle_no_activity", zeros, 0);
    check("idle_tready", tready[0], 1'b1);

    // Reset at clock 450 of a frame
    tdata     = 8'hA5;
    tvalid[0] = 1'b1;
    step();
    tvalid[0] = 1'b0;
    check("abort_start", tx[0], 1'b0);
    repeat (449) step();
    check("abort_pre_tx", tx[0], 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    check("abort_async_tx", tx[0], 1'b1);
    check("abort_async_tready", tready[0], 1'b1);
    repeat (3) @(negedge clk);
    check("abort_hold_tx", tx[0], 1'b1);
    aresetn = 1'b1;
    zeros = 0;
    repeat (300) begin
      step();
      if (tx[0] !== 1'b1) zeros++;
    end
    check("abort_no_resume", zeros, 0);
    frame_check(0, 8'h3C, 10, 12'b00_1_00111100_0, 1'b0, "post_abort_3c");

    // tdata scrambled during the frame with tvalid held
    frame_check(0, 8'h5A, 10, 12'b00_1_01011010_0, 1'b1, "rnd_5a");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_to_uart_tx.md
AXIS_TO_UART_TX -- requirements
Module: axis_to_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100, SHALL be the clock frequency in MHz.
REQ-002 Parameter BIT_RATE, default 115200, SHALL be the line rate in bit/s.
REQ-003 Parameter BIT_PER_WORD, default 8, SHALL be data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY_BIT, default 0, SHALL select parity: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS_NUM, default 1, SHALL be stop bits per frame; legal values 1 or 2.
REQ-006 axis_port.aclk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-007 axis_port.aresetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-008 axis_port.tdata  input  BIT_PER_WORD  SHALL carry the word to transmit.
REQ-009 axis_port.tvalid  input  1  SHALL mark tdata valid.
REQ-010 axis_port.tready  output  1  SHALL be high only when a new word can be accepted.
REQ-011 uart_port.TX  output  1  SHALL be the registered serial line; idle level 1.
REQ-012 axis_port.tuser SHALL be ignored.

Function
REQ-013 Bit period P SHALL be floor(CLK_FREQ*1000000/BIT_RATE) clocks; every line bit SHALL last exactly P clocks.
REQ-014 Clock counter width SHALL be clog2(P+1); bit counter width SHALL be clog2(BIT_PER_WORD+1).
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-016 tready SHALL be 1 in IDLE and 0 in every other state.
REQ-017 Handshake (tvalid&tready in cycle k) SHALL latch tdata into a shift register and enter START at k+1.
REQ-018 TX SHALL be 0 for cycles k+1..k+P (start bit).
REQ-019 DATA SHALL send BIT_PER_WORD bits LSB first, P clocks each.
REQ-020 After DATA: PARITY if PARITY_BIT != 0, else STOP1.
REQ-021 PARITY bit SHALL be ~^word (odd) or ^word (even), computed from the latched word, held P clocks.
REQ-022 STOP1 (and STOP2 when STOP_BITS_NUM=2) SHALL drive TX=1 for P clocks each, then return to IDLE.
REQ-023 Frame length SHALL be (1+BIT_PER_WORD+(PARITY_BIT!=0)+STOP_BITS_NUM)*P clocks from k+1.
REQ-024 Back-to-back: with tvalid held, the next handshake SHALL occur in the first IDLE cycle, giving exactly one idle TX=1 clock between frames.
REQ-025 tdata/tvalid changes while tready=0 SHALL not affect the frame in progress.
REQ-026 tvalid low in IDLE SHALL keep TX=1 and the FSM in IDLE indefinitely.

Reset
REQ-027 While aresetn=0: state IDLE, TX=1, counters 0, shift register 0, tready=1.
REQ-028 Reset asserted mid-frame SHALL force TX=1 immediately (asynchronously) and abort the frame; no partial resume after release.
REQ-029 The first handshake SHALL be possible on the first rising edge after aresetn deasserts.

Verification (CLK_FREQ=100, BIT_RATE=1000000, P=100)
REQ-030 8N1, single tdata=0xA5 -> TX = 0,1,0,1,0,0,1,0,1,1, 100 clocks each; tready low exactly 1000 clocks.
REQ-031 PARITY_BIT=2, tdata=0xA5 -> parity bit 0; PARITY_BIT=1 -> parity bit 1; frame 1100 clocks.
REQ-032 STOP_BITS_NUM=2, tdata=0x00 -> start + eight 0 bits + 200 clocks of TX=1; tready returns after 1100 clocks.
REQ-033 tvalid held high, words 0x01,0x80,0xFF -> three frames each separated by exactly one idle clock; a bench UART receiver decodes 0x01,0x80,0xFF.
REQ-034 aresetn pulsed low at clock 450 of a frame -> TX=1 during reset, tready=1, no further line activity until the next handshake; the next word transmits correctly.
REQ-035 tdata toggled randomly during a frame with tvalid=1 -> transmitted bits match the word latched at the handshake.
